// File: rtl/lab3_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// lab3_cache_mem_responder
//
// Main-memory responder for the cache refill/evict port. It accepts one
// mem_req_4B_t request at a time and services it from a word-wide storage
// array. After p_latency wait cycles it presents a mem_resp_4B_t response and
// holds it until the cache takes it. Only one request is outstanding at a
// time. It is used as the backing store in cache-level tests.
//
// Parameters
//   p_num_words  storage depth in 32-bit words (power of 2, >= 2)
//   p_latency    wait cycles between acceptance and response valid (0..15)
//
// Ports
//   clk          clock; all state updates on posedge
//   reset        asynchronous, active-high reset
//   memreq_val   request valid
//   memreq_rdy   responder can accept a request this cycle (IDLE only)
//   memreq_msg   {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
//   memresp_val  response valid
//   memresp_rdy  cache accepts the response this cycle
//   memresp_msg  {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
// ---------------------------------------------------------------------------
module lab3_cache_mem_responder #(
    parameter int unsigned p_num_words = 256,
    parameter int unsigned p_latency   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg
);

    localparam int unsigned IdxW = $clog2(p_num_words);
    localparam logic [3:0]  Lat  = 4'(p_latency);

    localparam logic [2:0] TypeRead  = 3'd0;
    localparam logic [2:0] TypeWrite = 3'd1;
    localparam logic [2:0] TypeInit  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // Byte-lane helpers
    // -----------------------------------------------------------------------

    // len encodes 4 bytes as 0. The mask covers bytes 0..nbytes-1.
    function automatic logic [3:0] len_mask(input logic [1:0] len);
        logic [3:0] m;
        case (len)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Read data is right-justified: the byte at the offset lands in lane 0.
    // Bytes past the requested length are zeroed.
    function automatic logic [31:0] read_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  len);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        return shifted & expand_mask(len_mask(len));
    endfunction

    // -----------------------------------------------------------------------
    // Request fields
    // -----------------------------------------------------------------------
    logic [2:0]      req_type;
    logic [7:0]      req_opaque;
    logic [31:0]     req_addr;
    logic [1:0]      req_len;
    logic [31:0]     req_data;
    logic [IdxW-1:0] req_idx;
    logic [1:0]      req_off;

    assign req_type   = memreq_msg[76:74];
    assign req_opaque = memreq_msg[73:66];
    assign req_addr   = memreq_msg[65:34];
    assign req_len    = memreq_msg[33:32];
    assign req_data   = memreq_msg[31:0];
    assign req_idx    = req_addr[IdxW+1:2];
    assign req_off    = req_addr[1:0];

    // Address bits above the word index alias onto the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IdxW+2];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e          state_q,  state_d;
    logic [3:0]      cnt_q,    cnt_d;
    logic [2:0]      type_q,   type_d;
    logic [7:0]      opaque_q, opaque_d;
    logic [1:0]      len_q,    len_d;
    logic [IdxW-1:0] idx_q,    idx_d;
    logic [1:0]      off_q,    off_d;
    logic [46:0]     resp_q,   resp_d;

    logic [31:0] mem_q [p_num_words];

    logic req_fire;

    // Acceptance depends only on state; while reset is high nothing is taken.
    assign memreq_rdy  = (state_q == ST_IDLE) && !reset;
    assign req_fire    = memreq_val && memreq_rdy;
    assign memresp_val = (state_q == ST_RESP);
    assign memresp_msg = resp_q;

    // -----------------------------------------------------------------------
    // Storage write: byte-masked and committed on the acceptance edge.
    // Lanes shifted past byte 3 fall off the 4-bit mask and are not written.
    // -----------------------------------------------------------------------
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_lane;

    assign wr_en   = req_fire && ((req_type == TypeWrite) || (req_type == TypeInit));
    assign wr_be   = len_mask(req_len) << req_off;
    assign wr_lane = req_data << {req_off, 3'b000};

    // NOTE: the storage array has no reset. Clearing it would prevent RAM
    // inference, and its contents must survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < 4; j++) begin
                if (wr_be[j]) begin
                    mem_q[req_idx][8*j +: 8] <= wr_lane[8*j +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response source. When p_latency is 0, RESP is entered from IDLE on the
    // acceptance edge, so the live request fields are used. Otherwise the
    // latched copy is used. A read always samples storage as RESP is entered.
    // -----------------------------------------------------------------------
    logic            src_live;
    logic [2:0]      src_type;
    logic [7:0]      src_opaque;
    logic [1:0]      src_len;
    logic [IdxW-1:0] src_idx;
    logic [1:0]      src_off;
    logic [31:0]     src_data;

    assign src_live   = (state_q == ST_IDLE);
    assign src_type   = src_live ? req_type   : type_q;
    assign src_opaque = src_live ? req_opaque : opaque_q;
    assign src_len    = src_live ? req_len    : len_q;
    assign src_idx    = src_live ? req_idx    : idx_q;
    assign src_off    = src_live ? req_off    : off_q;
    assign src_data   = (src_type == TypeRead)
                        ? read_extract(mem_q[src_idx], src_off, src_len)
                        : 32'h0;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            type_q   <= 3'd0;
            opaque_q <= 8'd0;
            len_q    <= 2'd0;
            idx_q    <= '0;
            off_q    <= 2'd0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            opaque_q <= opaque_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            resp_q   <= resp_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a hold default first. Any path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        opaque_d = opaque_q;
        len_d    = len_q;
        idx_d    = idx_q;
        off_d    = off_q;
        resp_d   = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    type_d   = req_type;
                    opaque_d = req_opaque;
                    len_d    = req_len;
                    idx_d    = req_idx;
                    off_d    = req_off;
                    if (Lat == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = Lat;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Returning to IDLE on the handshake keeps the next acceptance
                // one cycle after the response fires.
                if (memresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Load the response exactly once, on the edge that enters RESP.
        // It is then held stable under backpressure.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            resp_d = {src_type, src_opaque, 2'b00, src_len, src_data};
        end
    end

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lab3_cache_mem_responder
//
// Directed bench with two responders. dut_a uses p_latency=2 and covers reset,
// read/write/init, byte lanes, backpressure, aliasing and reset
// mid-transaction. dut_b uses p_latency=0 and covers latency and back-to-back
// throughput. Inputs change on the falling edge, outputs are sampled there,
// and the rising edge performs the handshakes.
// ---------------------------------------------------------------------------
module tb_lab3_cache_mem_responder;

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;
    localparam logic [2:0] T_INIT  = 3'd2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        a_req_val  = 1'b0;
    logic        a_req_rdy;
    logic [76:0] a_req_msg  = '0;
    logic        a_resp_val;
    logic        a_resp_rdy = 1'b0;
    logic [46:0] a_resp_msg;

    logic        b_req_val  = 1'b0;
    logic        b_req_rdy;
    logic [76:0] b_req_msg  = '0;
    logic        b_resp_val;
    logic        b_resp_rdy = 1'b0;
    logic [46:0] b_resp_msg;

    int unsigned cyc   = 0;
    int unsigned t_acc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lab3_cache_mem_responder #(.p_num_words(256), .p_latency(2)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (a_req_val),
        .memreq_rdy  (a_req_rdy),
        .memreq_msg  (a_req_msg),
        .memresp_val (a_resp_val),
        .memresp_rdy (a_resp_rdy),
        .memresp_msg (a_resp_msg)
    );

    lab3_cache_mem_responder #(.p_num_words(256), .p_latency(0)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (b_req_val),
        .memreq_rdy  (b_req_rdy),
        .memreq_msg  (b_req_msg),
        .memresp_val (b_resp_val),
        .memresp_rdy (b_resp_rdy),
        .memresp_msg (b_resp_msg)
    );

    function automatic logic [76:0] mk_req(input logic [2:0] typ, input logic [7:0] opq,
                                           input logic [31:0] addr, input logic [1:0] len,
                                           input logic [31:0] data);
        return {typ, opq, addr, len, data};
    endfunction

    function automatic logic [46:0] mk_resp(input logic [2:0] typ, input logic [7:0] opq,
                                            input logic [1:0] len, input logic [31:0] data);
        return {typ, opq, 2'b00, len, data};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for memreq_rdy, then present one request on dut_a. Returns at the
    // falling edge after acceptance, with t_acc set to the acceptance edge.
    task automatic a_send(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] data);
        int n = 0;
        while (a_req_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("a_req_rdy_timeout", 64'(a_req_rdy), 64'd1);
        a_req_val = 1'b1;
        a_req_msg = mk_req(typ, opq, addr, len, data);
        @(posedge clk);
        @(negedge clk);
        a_req_val = 1'b0;
        t_acc     = cyc;
    endtask

    // Wait for the response and check it. Hold it under backpressure for
    // 'hold' cycles, then complete the handshake. With p_latency=2, valid is
    // first visible in the cycle after edge t_acc+2.
    task automatic a_recv(input string tag, input logic [46:0] exp, input int hold);
        int n = 0;
        while (a_resp_val !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_val"}, 64'(a_resp_val), 64'd1);
        check({tag, "_lat"}, 64'(cyc - t_acc), 64'd2);
        check({tag, "_msg"}, 64'(a_resp_msg), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_val"}, 64'(a_resp_val), 64'd1);
            check({tag, "_hold_msg"}, 64'(a_resp_msg), 64'(exp));
            check({tag, "_hold_req_rdy"}, 64'(a_req_rdy), 64'd0);
        end
        a_resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_resp_rdy = 1'b0;
        check({tag, "_done_val"}, 64'(a_resp_val), 64'd0);
        check({tag, "_done_req_rdy"}, 64'(a_req_rdy), 64'd1);
    endtask

    task automatic a_xact(input string tag, input logic [2:0] typ, input logic [7:0] opq,
                          input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int hold);
        a_send(typ, opq, addr, len, wdata);
        a_recv(tag, mk_resp(typ, opq, len, exp_data), hold);
    endtask

    // Watch dut_a for n cycles with memresp_rdy low. No response may appear.
    task automatic a_no_stale(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (a_resp_val !== 1'b0) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    // Eight back-to-back requests on dut_b (p_latency=0) with memresp_rdy held
    // high. Request k targets word k with opaque k. Reads return base+k.
    task automatic b_stream(input string tag, input logic [2:0] typ, input logic [31:0] base);
        int          k = 0;
        int          got = 0;
        int unsigned start, first, last;
        logic        acc;
        first = 0;
        last  = 0;
        b_resp_rdy = 1'b1;
        @(negedge clk);
        b_req_val = 1'b1;
        b_req_msg = mk_req(typ, 8'(k), 32'(k * 4), 2'd0, base + 32'(k));
        start     = cyc;
        for (int c = 0; c < 64 && got < 8; c++) begin
            if (b_resp_val === 1'b1) begin
                check({tag, "_msg"}, 64'(b_resp_msg),
                      64'(mk_resp(typ, 8'(got), 2'd0, (typ == T_READ) ? base + 32'(got) : 32'h0)));
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
            acc = b_req_rdy && b_req_val;
            @(negedge clk);
            if (acc) begin
                k++;
                if (k < 8) b_req_msg = mk_req(typ, 8'(k), 32'(k * 4), 2'd0, base + 32'(k));
                else       b_req_val = 1'b0;
            end
        end
        @(negedge clk);
        b_resp_rdy = 1'b0;
        check({tag, "_count"}, 64'(got), 64'd8);
        // First accept at edge start+1, so valid is visible in the next cycle.
        check({tag, "_lat0"}, 64'(first - start), 64'd1);
        // The last handshake falls 16 cycles after the first request was presented.
        check({tag, "_span"}, 64'(last + 1 - start), 64'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_req_rdy", 64'(a_req_rdy), 64'd0);
        check("rst_resp_val", 64'(a_resp_val), 64'd0);
        check("rst_resp_msg", 64'(a_resp_msg), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_req_rdy", 64'(a_req_rdy), 64'd1);

        // 1: init then full-word read
        a_xact("t1_init", T_INIT, 8'h01, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0, 0);
        a_xact("t1_read", T_READ, 8'h05, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, 0);

        // 2: single-byte write, full read, sub-word read at offset 3
        a_xact("t2_write", T_WRITE, 8'h02, 32'h100, 2'd1, 32'h000000AA, 32'h0, 0);
        a_xact("t2_read_w", T_READ, 8'h03, 32'h100, 2'd0, 32'h0, 32'hDEADBEAA, 0);
        a_xact("t2_read_b", T_READ, 8'h04, 32'h103, 2'd1, 32'h0, 32'h000000DE, 0);

        // 3: response held for 5 cycles of backpressure
        a_xact("t3_bp", T_READ, 8'h07, 32'h100, 2'd0, 32'h0, 32'hDEADBEAA, 5);

        // 4: address aliasing and half-word read
        a_xact("t4_write", T_WRITE, 8'h10, 32'h00000400, 2'd0, 32'h12345678, 32'h0, 0);
        a_xact("t4_alias", T_READ, 8'h11, 32'h00000000, 2'd0, 32'h0, 32'h12345678, 0);
        a_xact("t4_half", T_READ, 8'h12, 32'h00000402, 2'd2, 32'h0, 32'h00001234, 0);

        // Lanes past byte 3 are dropped, with no spill into the next word
        a_xact("ln_init1", T_INIT, 8'h1F, 32'h204, 2'd0, 32'h00000000, 32'h0, 0);
        a_xact("ln_init0", T_INIT, 8'h20, 32'h200, 2'd0, 32'h11223344, 32'h0, 0);
        a_xact("ln_write", T_WRITE, 8'h21, 32'h203, 2'd2, 32'h0000BBCC, 32'h0, 0);
        a_xact("ln_read", T_READ, 8'h22, 32'h200, 2'd0, 32'h0, 32'hCC223344, 0);
        a_xact("ln_read3", T_READ, 8'h23, 32'h201, 2'd3, 32'h0, 32'h00CC2233, 0);
        a_xact("ln_nospill", T_READ, 8'h24, 32'h204, 2'd0, 32'h0, 32'h00000000, 0);
        a_xact("ln_rd_edge", T_READ, 8'h27, 32'h203, 2'd2, 32'h0, 32'h000000CC, 0);

        // An unknown type leaves storage untouched and returns data 0
        a_xact("unk_type", 3'd5, 8'h25, 32'h200, 2'd0, 32'hFFFFFFFF, 32'h0, 0);
        a_xact("unk_after", T_READ, 8'h26, 32'h200, 2'd0, 32'h0, 32'hCC223344, 0);

        // 6: reset during WAIT of a write. The write stays, and no response follows.
        a_send(T_WRITE, 8'h30, 32'h300, 2'd0, 32'hCAFEF00D);
        reset = 1'b1;
        #1;
        check("t6_wait_rst_val", 64'(a_resp_val), 64'd0);
        check("t6_wait_rst_rdy", 64'(a_req_rdy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        a_no_stale("t6_wait_no_stale", 8);

        // Reset during WAIT of a read
        a_send(T_READ, 8'h32, 32'h100, 2'd0, 32'h0);
        reset = 1'b1;
        #1;
        check("t6_rd_rst_val", 64'(a_resp_val), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        a_no_stale("t6_rd_no_stale", 8);

        // Reset while a response is valid drops it immediately
        a_send(T_READ, 8'h31, 32'h100, 2'd0, 32'h0);
        repeat (2) @(negedge clk);
        check("t6_resp_pre_val", 64'(a_resp_val), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_resp_rst_val", 64'(a_resp_val), 64'd0);
        check("t6_resp_rst_msg", 64'(a_resp_msg), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        a_no_stale("t6_resp_no_stale", 6);

        a_xact("t6_read_w", T_READ, 8'h33, 32'h300, 2'd0, 32'h0, 32'hCAFEF00D, 0);
        a_xact("t6_read_old", T_READ, 8'h34, 32'h100, 2'd0, 32'h0, 32'hDEADBEAA, 0);

        // 5: zero latency, back-to-back throughput and in-order opaques
        b_stream("t5_init", T_INIT, 32'hC0DE0000);
        b_stream("t5_read", T_READ, 32'hC0DE0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
